// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// bus widths and the address legality check used on every request.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  // A request is legal when it is word aligned and its word index falls
  // inside the array. The index is widened so the compare never truncates.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       depth_words);
    logic [ADDR_W-1:0] word_idx;
    word_idx = {2'b00, addr[ADDR_W-1:2]};
    return (addr[1:0] == 2'b00) && (word_idx < depth_words);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte-lane write enables.
// One address serves both the write and the registered read; a read in the
// same cycle as a write to the same word returns the old contents.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Lane-masked write and registered read; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS MEM-stage load/store port.
// Accepts one word request at a time, inserts LATENCY cycles of wait
// states and then presents the response until it is consumed.
// Optional feature macro: DMEM_BYTE_STROBE_EN adds req_be[3:0] so stores
// write only the enabled byte lanes; without it every legal store writes
// the full word.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]        req_be,
`endif
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t            state;
  state_t            state_nx;
  logic [3:0]        cnt;
  logic              accept;
  logic              req_legal;

  // Request fields captured at accept and held for the whole transaction.
  logic              we_p0;
  logic              err_p0;
  logic [AW-1:0]     idx_p0;

  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [DATA_W-1:0] ram_q;

  assign req_legal = addr_legal(req_addr, DEPTH_WORDS);

  // While idle the RAM looks at the incoming address so that a single-cycle
  // latency still has the word ready on the edge entering RESP; afterwards
  // it keeps reading the latched word, so ram_q stays stable while waiting.
  assign ram_addr = (state == IDLE) ? req_addr[AW+1:2] : idx_p0;
  assign ram_we   = accept & req_we & req_legal;

`ifdef DMEM_BYTE_STROBE_EN
  assign ram_be = req_be;
`else
  assign ram_be = 4'hF;
`endif

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (req_wdata),
    .rdata (ram_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = ~rst;
        if (req_valid && !rst) begin
          accept   = 1'b1;
          state_nx = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Wait-state counter: loaded on accept, counts down while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= CNT_INIT;
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Accept boundary: capture request kind and legality.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_p0  <= 1'b0;
      err_p0 <= 1'b0;
    end else if (accept) begin
      we_p0  <= req_we;
      err_p0 <= ~req_legal;
    end
  end

  // Accept boundary: capture the word index (data path, not reset).
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_p0 <= req_addr[AW+1:2];
    end
  end

  // Response fields are only driven while a response is presented; stores
  // and errored requests return zero data.
  assign resp_err   = resp_valid & err_p0;
  assign resp_rdata = (resp_valid && !we_p0 && !err_p0) ? ram_q : '0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        r1_valid, r1_ready, r1_we;
  logic [31:0] r1_addr, r1_wdata;
  logic [3:0]  r1_be;
  logic        p1_valid, p1_ready, p1_err;
  logic [31:0] p1_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be     (req_be),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (r1_valid),
    .req_ready  (r1_ready),
    .req_we     (r1_we),
    .req_addr   (r1_addr),
    .req_wdata  (r1_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be     (r1_be),
`endif
    .resp_valid (p1_valid),
    .resp_ready (p1_ready),
    .resp_rdata (p1_rdata),
    .resp_err   (p1_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Starts and ends on a negedge with the main DUT idle.
  task automatic txn(input string nm, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b,
                     input logic e_err, input logic [31:0] e_rd);
    int n;
    chk({nm, " req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = w; req_addr = a; req_wdata = d; req_be = b;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, LAT);
    chk({nm, " err"}, {31'd0, resp_err}, {31'd0, e_err});
    chk({nm, " rdata"}, resp_rdata, e_rd);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({nm, " resp_valid drop"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    int n;
    tbl[0] = '{1'b1, 32'd2000, 32'h0001E87C, 1'b0, 32'd0};
    tbl[1] = '{1'b0, 32'd2000, 32'd0,        1'b0, 32'd125052};
    tbl[2] = '{1'b1, 32'd0,    32'h12345678, 1'b0, 32'd0};
    tbl[3] = '{1'b0, 32'd2002, 32'd0,        1'b1, 32'd0};
    tbl[4] = '{1'b1, 32'd4096, 32'hDEADBEEF, 1'b1, 32'd0};
    tbl[5] = '{1'b0, 32'd0,    32'd0,        1'b0, 32'h12345678};
    tbl[6] = '{1'b1, 32'd2004, 32'd17,       1'b0, 32'd0};
    tbl[7] = '{1'b1, 32'd4092, 32'hCAFEF00D, 1'b0, 32'd0};
    tbl[8] = '{1'b0, 32'd4092, 32'd0,        1'b0, 32'hCAFEF00D};
    tbl[9] = '{1'b0, 32'd4096, 32'd0,        1'b1, 32'd0};

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_be = 4'hF; resp_ready = 1'b0;
    r1_valid = 1'b0; r1_we = 1'b0; r1_addr = 32'd0; r1_wdata = 32'd0;
    r1_be = 4'hF; p1_ready = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst resp_err", {31'd0, resp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, 4'hF,
          tbl[i].err, tbl[i].rdata);
    end

    // Response back-pressure: outputs held, new requests ignored.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd2000;
    @(negedge clk);
    req_addr = 32'd0;
    n = 1;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold latency", n, LAT);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d valid", i), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("hold%0d rdata", i), resp_rdata, 32'd125052);
      chk($sformatf("hold%0d req_ready", i), {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("hold idle valid", {31'd0, resp_valid}, 32'd0);
    chk("hold idle req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("after hold latency", n, LAT);
    chk("after hold rdata", resp_rdata, 32'h12345678);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Reset during WAIT drops the pending load.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd2004;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstwait in wait", {31'd0, resp_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstwait valid", {31'd0, resp_valid}, 32'd0);
    chk("rstwait req_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rstwait quiet%0d", i), {31'd0, resp_valid}, 32'd0);
    end
    txn("post rst load", 1'b0, 32'd2004, 32'd0, 4'hF, 1'b0, 32'd17);

    // LATENCY=1 instance: one response every other cycle.
    r1_valid = 1'b1; r1_we = 1'b1; r1_addr = 32'd8; r1_wdata = 32'h55;
    p1_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      r1_we = 1'b0;
      chk($sformatf("lat1 c%0d valid", i), {31'd0, p1_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("lat1 c%0d ready", i), {31'd0, r1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i >= 2 && i % 2 == 0) begin
        chk($sformatf("lat1 c%0d rdata", i), p1_rdata, 32'h55);
      end
    end
    r1_valid = 1'b0;
    p1_ready = 1'b0;
    @(negedge clk);

`ifdef DMEM_BYTE_STROBE_EN
    txn("be full", 1'b1, 32'd0, 32'h000F0008, 4'hF, 1'b0, 32'd0);
    txn("be lane1", 1'b1, 32'd0, 32'hAABBCCDD, 4'b0010, 1'b0, 32'd0);
    txn("be load1", 1'b0, 32'd0, 32'd0, 4'hF, 1'b0, 32'h000FCC08);
    txn("be none", 1'b1, 32'd0, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'd0);
    txn("be load2", 1'b0, 32'd0, 32'd0, 4'hF, 1'b0, 32'h000FCC08);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
